// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  // Loader frame-parsing states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CNT_LO,
    ST_CNT_HI,
    ST_DATA,
    ST_WRITE,
    ST_CHECK,
    ST_OK,
    ST_FAIL
  } state_e;

  localparam logic [7:0] MAGIC_DEFAULT   = 8'hA5;
  localparam int         FRAME_HDR_BYTES = 3;
  localparam int         BYTES_PER_WORD  = 4;

  // True for the states that sit between frames and wait for a start byte.
  function automatic logic is_between_frames(input state_e s);
    return (s == ST_IDLE) || (s == ST_OK) || (s == ST_FAIL);
  endfunction

endpackage

// File: rtl/imem_loader.sv
// Frames a byte stream into 32-bit words, drives the IMEM write port and
// keeps the core held while a program is being loaded.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         ADDR_W    = 10,
  parameter logic [7:0] MAGIC     = MAGIC_DEFAULT,
  parameter int         TIMEOUT   = 100000,
  parameter logic       BOOT_HOLD = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic              rx_ready_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_address_o,
  output logic [31:0]       wr_data_o,
  output logic              cpu_hold_o,
  output logic              done_o,
  output logic              error_o
);

  localparam int               TMR_W    = $clog2(TIMEOUT + 1);
  localparam logic [16:0]      DEPTH    = 17'(1) << ADDR_W;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [7:0]         cntLo_q, cntLo_d;
  logic [16:0]        wordsLeft_q, wordsLeft_d;
  logic [1:0]         byteIdx_q, byteIdx_d;
  logic [31:0]        word_q, word_d;
  logic [7:0]         chk_q, chk_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W-1:0]  wrAddr_q, wrAddr_d;
  logic [31:0]        wrData_q, wrData_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               hold_q, hold_d;
  logic               done_q, done_d;
  logic               error_q, error_d;

  logic               accept;
  logic               inFrame;
  logic [15:0]        count;
  logic [31:0]        assembled;

  assign accept    = rx_valid_i && (state_q != ST_WRITE);
  assign inFrame   = !is_between_frames(state_q);
  assign count     = {rx_data_i, cntLo_q};
  assign assembled = {rx_data_i, word_q[31:8]};

  assign rx_ready_o   = (state_q != ST_WRITE);
  assign wr_en_o      = (state_q == ST_WRITE);
  assign wr_address_o = wrAddr_q;
  assign wr_data_o    = wrData_q;
  assign cpu_hold_o   = hold_q;
  assign done_o       = done_q;
  assign error_o      = error_q;

  // State register and datapath registers; reset discards any frame in progress.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cntLo_q     <= '0;
      wordsLeft_q <= '0;
      byteIdx_q   <= '0;
      word_q      <= '0;
      chk_q       <= '0;
      addr_q      <= '0;
      wrAddr_q    <= '0;
      wrData_q    <= '0;
      timer_q     <= '0;
      hold_q      <= BOOT_HOLD;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cntLo_q     <= cntLo_d;
      wordsLeft_q <= wordsLeft_d;
      byteIdx_q   <= byteIdx_d;
      word_q      <= word_d;
      chk_q       <= chk_d;
      addr_q      <= addr_d;
      wrAddr_q    <= wrAddr_d;
      wrData_q    <= wrData_d;
      timer_q     <= timer_d;
      hold_q      <= hold_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  // Frame parser: next state, byte assembly, checksum, write-port and status updates.
  always_comb begin
    state_d     = state_q;
    cntLo_d     = cntLo_q;
    wordsLeft_d = wordsLeft_q;
    byteIdx_d   = byteIdx_q;
    word_d      = word_q;
    chk_d       = chk_q;
    addr_d      = addr_q;
    wrAddr_d    = wrAddr_q;
    wrData_d    = wrData_q;
    hold_d      = hold_q;
    done_d      = done_q;
    error_d     = error_q;
    timer_d     = (!inFrame || accept) ? '0 : timer_q + TMR_W'(1);

    case (state_q)
      ST_IDLE, ST_OK, ST_FAIL: begin
        if (accept && (rx_data_i == MAGIC)) begin
          state_d     = ST_CNT_LO;
          hold_d      = 1'b1;
          done_d      = 1'b0;
          error_d     = 1'b0;
          addr_d      = '0;
          chk_d       = '0;
          byteIdx_d   = '0;
          wordsLeft_d = '0;
        end
      end
      ST_CNT_LO: begin
        if (accept) begin
          cntLo_d = rx_data_i;
          state_d = ST_CNT_HI;
        end
      end
      ST_CNT_HI: begin
        if (accept) begin
          if (count == 16'd0) begin
            state_d = ST_CHECK;
          end else if ({1'b0, count} > DEPTH) begin
            state_d = ST_FAIL;
            error_d = 1'b1;
            hold_d  = 1'b1;
          end else begin
            wordsLeft_d = {1'b0, count};
            state_d     = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (accept) begin
          word_d    = assembled;
          chk_d     = chk_q ^ rx_data_i;
          byteIdx_d = byteIdx_q + 2'd1;
          if (byteIdx_q == 2'(BYTES_PER_WORD - 1)) begin
            wrData_d = assembled;
            wrAddr_d = addr_q;
            state_d  = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        addr_d      = addr_q + ADDR_W'(1);
        wordsLeft_d = wordsLeft_q - 17'd1;
        state_d     = (wordsLeft_q == 17'd1) ? ST_CHECK : ST_DATA;
      end
      ST_CHECK: begin
        if (accept) begin
          if (rx_data_i == chk_q) begin
            state_d = ST_OK;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = ST_FAIL;
            error_d = 1'b1;
            hold_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (inFrame && !accept && (timer_q == TMR_LAST)) begin
      state_d = ST_FAIL;
      error_d = 1'b1;
      hold_d  = 1'b1;
    end
  end

endmodule
